// File: rtl/seq_restoring_div_4bit_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package seq_restoring_div_4bit_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage : seq_restoring_div_4bit_pkg

// File: rtl/seq_restoring_div_4bit_sub.sv
// Ripple-borrow subtractor (Diff = X - Y - Bin) assembled from 1-bit
// full-subtractor cells; used for the trial subtraction of each divide step.
module full_sub_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule : full_sub_1bit

module ripple_borrow_sub_5bit #(
  parameter int N = 5
) (
  output logic [N-1:0] Diff,
  output logic         Bout,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         Bin
);
  logic [N:0] w_borrow;

  assign w_borrow[0] = Bin;

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    full_sub_1bit u_cell (
      .i_a    (X[gi]),
      .i_b    (Y[gi]),
      .i_bin  (w_borrow[gi]),
      .o_d    (Diff[gi]),
      .o_bout (w_borrow[gi+1])
    );
  end

  assign Bout = w_borrow[N];
endmodule : ripple_borrow_sub_5bit

// File: rtl/seq_restoring_div_4bit.sv
// Sequential unsigned restoring divider: one quotient bit per CALC cycle,
// MSB first, with a divide-by-zero shortcut straight to FIN.
module seq_restoring_div_4bit
  import seq_restoring_div_4bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz
);
  localparam int                CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dividend, r_divisor, r_quo, r_q, r_r;
  logic [WIDTH:0]     r_prem, w_t, w_diff;
  logic               w_bout, r_done, r_dbz, w_busy;
  logic               w_unused_prem_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero before each shift.
  assign w_unused_prem_msb = r_prem[WIDTH];
  assign w_t = {r_prem[WIDTH-1:0], r_dividend[WIDTH-1]};

  ripple_borrow_sub_5bit #(.N(WIDTH + 1)) u_sub (
    .Diff (w_diff),
    .Bout (w_bout),
    .X    (w_t),
    .Y    ({1'b0, r_divisor}),
    .Bin  (1'b0)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next_state = (Y == '0) ? FIN : CALC;
      CALC: begin
        w_busy = 1'b1;
        if (r_cnt == LAST) w_next_state = FIN;
      end
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register here samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quo      <= '0;
      r_prem     <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: if (start) begin
          r_dividend <= X;
          r_divisor  <= Y;
          r_cnt      <= '0;
          r_dbz      <= (Y == '0);
          if (Y == '0) begin
            r_quo  <= '1;
            r_prem <= {1'b0, X};
          end else begin
            r_quo  <= '0;
            r_prem <= '0;
          end
        end
        CALC: begin
          r_dividend <= r_dividend << 1;
          r_prem     <= w_bout ? w_t : w_diff;
          r_quo      <= {r_quo[WIDTH-2:0], ~w_bout};
          if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
        end
        FIN: begin
          r_q    <= r_quo;
          r_r    <= r_prem[WIDTH-1:0];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign busy = w_busy;
  assign done = r_done;
  assign dbz  = r_dbz;
endmodule : seq_restoring_div_4bit

// File: tb/tb_seq_restoring_div_4bit.sv
// Self-checking bench for seq_restoring_div_4bit: directed cases plus random
// operands compared against an arithmetic reference model.
module tb_seq_restoring_div_4bit;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] X, Y, Q, R;
  logic       busy, done, dbz;
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  seq_restoring_div_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
    .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, all-ones quotient on a zero divisor.
  task automatic model(input logic [3:0] x, input logic [3:0] y,
                       output logic [3:0] q, output logic [3:0] r, output logic z);
    if (y == 0) begin
      q = 4'hF; r = x; z = 1'b1;
    end else begin
      q = 4'(int'(x) / int'(y)); r = 4'(int'(x) % int'(y)); z = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_div(input logic [3:0] x, input logic [3:0] y, input string tag);
    logic [3:0] eq, er;
    logic       ez;
    int         lat, busy_cnt, overlap;
    model(x, y, eq, er, ez);
    @(negedge clk);
    start = 1'b1; X = x; Y = y;
    step();
    start = 1'b0;
    check({tag, ".dbz_at_accept"}, dbz, ez);
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    if (busy && done) overlap = 1;
    check({tag, ".latency"}, lat, (y == 0) ? 1 : 5);
    check({tag, ".busy_cycles"}, busy_cnt, (y == 0) ? 0 : 4);
    check({tag, ".busy_done_overlap"}, overlap, 0);
    check({tag, ".Q"}, Q, eq);
    check({tag, ".R"}, R, er);
    check({tag, ".dbz"}, dbz, ez);
    step();
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".Q_hold"}, Q, eq);
  endtask

  initial begin
    logic [3:0] eq, er;
    logic       ez;
    int         n_done, t_done, last_done, lat;

    rst = 1'b1; start = 1'b0; X = '0; Y = '0;
    step(); step();
    check("reset.Q", Q, 4'h0);
    check("reset.R", R, 4'h0);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.dbz", dbz, 1'b0);
    @(negedge clk); rst = 1'b0;

    do_div(4'd13, 4'd5,  "d13_5");
    do_div(4'd5,  4'd13, "d5_13");
    do_div(4'd11, 4'd11, "d11_11");
    do_div(4'd15, 4'd1,  "d15_1");
    do_div(4'd7,  4'd0,  "d7_0");
    do_div(4'd0,  4'd3,  "d0_3");

    // Start re-pulsed and operands changed during CALC must be ignored.
    @(negedge clk); start = 1'b1; X = 4'd12; Y = 4'd8;
    step();
    start = 1'b1; X = 4'd1; Y = 4'd1;
    step();
    X = 4'd3; Y = 4'd7;
    step();
    start = 1'b0; X = 4'd15; Y = 4'd0;
    n_done = 0; lat = 2; t_done = 0;
    for (int i = 0; i < 12; i++) begin
      step(); lat++;
      if (done) begin
        n_done++; t_done = lat;
        check("ignore.Q", Q, 4'd1);
        check("ignore.R", R, 4'd4);
      end
    end
    check("ignore.done_count", n_done, 1);
    check("ignore.latency", t_done, 5);

    // Reset in the second CALC cycle aborts without a done pulse.
    @(negedge clk); start = 1'b1; X = 4'd13; Y = 4'd5;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort.Q", Q, 4'h0);
    check("abort.R", R, 4'h0);
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    check("abort.dbz", dbz, 1'b0);
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) n_done++;
    end
    check("abort.no_done", n_done, 0);
    do_div(4'd9, 4'd2, "after_abort");

    // Start held high: back-to-back operations every 6 cycles.
    model(4'd14, 4'd3, eq, er, ez);
    @(negedge clk); start = 1'b1; X = 4'd14; Y = 4'd3;
    last_done = -1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      step();
      while (!done && lat < 20) begin
        step(); lat++;
      end
      check("b2b.seen_done", done, 1'b1);
      check("b2b.Q", Q, eq);
      check("b2b.R", R, er);
      if (last_done >= 0) check("b2b.period", cyc - last_done, 6);
      last_done = cyc;
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Random operands, including occasional zero divisors.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] rx, ry;
      rx = 4'($urandom_range(0, 15));
      ry = (i % 6 == 5) ? 4'd0 : 4'($urandom_range(0, 15));
      do_div(rx, ry, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule : tb_seq_restoring_div_4bit

// File: doc/seq_restoring_div_4bit.md
SEQ_RESTORING_DIV_4BIT -- requirements
Module: seq_restoring_div_4bit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width (only 4 is required to be verified).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port start, input, 1, a request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port X, input, WIDTH, the unsigned dividend; captured on accepted start.
REQ-006 SHALL have port Y, input, WIDTH, the unsigned divisor; captured on accepted start.
REQ-007 SHALL have port Q, output, WIDTH, the quotient; registered.
REQ-008 SHALL have port R, output, WIDTH, the remainder; registered.
REQ-009 SHALL have port busy, output, 1, high in CALC.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-011 SHALL have port dbz, output, 1, the divide-by-zero flag, valid with done.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FIN.
REQ-013 SHALL leave IDLE only when start=1: if Y!=0, go to CALC with a 3-bit step counter=0, X and Y captured, and the 5-bit partial remainder=0.
REQ-014 SHALL go from IDLE to FIN when start=1 and Y==0, setting Q=4'b1111, R=X, dbz=1; no CALC cycles.
REQ-015 SHALL perform one restoring step per CALC cycle, processing dividend bits MSB first: shift the partial remainder left and append the next dividend bit, giving T; then compute D=T-{0,Y} with the borrow-subtractor sub-module (Bin=0).
REQ-016 When Bout=0, SHALL set remainder=D and the quotient bit to 1; when Bout=1, SHALL keep remainder=T and set the quotient bit to 0.
REQ-017 SHALL spend exactly WIDTH (4) cycles in CALC, then go to FIN; the counter SHALL not wrap past WIDTH-1.
REQ-018 SHALL, in FIN, assert done=1 for exactly one cycle and load Q and R (R = the low WIDTH bits of the final remainder), then return to IDLE.
REQ-019 Latency: SHALL make done high exactly 5 cycles after the start-accept edge for Y!=0, and 1 cycle after it for Y==0.
REQ-020 SHALL hold Q, R and dbz from FIN until the next accepted start; a new start SHALL clear dbz.
REQ-021 SHALL ignore start while in CALC or FIN, with no effect on the result in progress.
REQ-022 SHALL accept start=1 in the IDLE cycle immediately after FIN (back-to-back operations).
REQ-023 SHALL hold busy=1 exactly in CALC; busy and done SHALL never both be high.
REQ-024 SHALL not change captured operands if X or Y change during CALC.

Reset
REQ-025 When rst=1 at a clock edge, SHALL force state=IDLE, Q=0, R=0, busy=0, done=0, dbz=0, counter=0 and partial remainder=0.
REQ-026 rst SHALL take priority over start and over any in-progress division; a division aborted mid-CALC SHALL produce no done pulse.

Structure
REQ-027 SHALL have a shared package holding the state encoding (IDLE=2'b00, CALC=2'b01, FIN=2'b10) and the WIDTH default.
REQ-028 SHALL instantiate exactly one sub-module, ripple_borrow_sub_5bit (ports Diff, Bout, X, Y, Bin), built from 1-bit full-subtractor cells.
REQ-029 SHALL contain no combinational "/" or "%" operators.

Verification
REQ-030 X=13, Y=5, start for 1 cycle -> busy high for 4 cycles, then done with Q=2, R=3, dbz=0.
REQ-031 X=5, Y=13 -> Q=0, R=5; and X=11, Y=11 -> Q=1, R=0; and X=15, Y=1 -> Q=15, R=0.
REQ-032 X=7, Y=0 -> done 1 cycle after start, Q=15, R=7, dbz=1, busy never high.
REQ-033 X=12, Y=8 accepted, start pulsed again with X=1, Y=1 during CALC, X/Y changed mid-CALC -> Q=1, R=4, one done only.
REQ-034 rst asserted in the 2nd CALC cycle -> no done, all outputs 0 next cycle; a fresh start with X=9, Y=2 then gives Q=4, R=1.
REQ-035 Back-to-back: start held high continuously with X=14, Y=3 -> done every 6 cycles, each time Q=4, R=2.
